wb_fetch: RTL and testbench
===========================

WB_FETCH -- requirements
Module: wb_fetch

Interface
REQ-001 Parameters SHALL be: WIDTH = 8, data width; CBITS = 10, transfer-count width; FBITS = 2, FIFO depth 2^FBITS = 4 words; DELAY = 3, register assignment delay in ns (simulation only).
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk_i  in  1  system clock; the single clock for the block.
  rst_i  in  1  asynchronous, active-high reset.
  start_i  in  1  one-cycle fetch request; sampled only in IDLE.
  count_i  in  CBITS  number of words to fetch; latched with start_i.
  abort_i  in  1  stop issuing new requests; sampled in FETCH only.
  busy_o  out  1  high in any state other than IDLE.
  done_o  out  1  one-cycle pulse when a fetch completes or is aborted.
  m_cyc_o  out  1  Wishbone cycle, to the wb_stream slave port.
  m_stb_o  out  1  read strobe.
  m_we_o  out  1  constant 0 (read-only master).
  m_bst_o  out  1  burst hint; more requests follow.
  m_ack_i  in  1  read data valid.
  m_wat_i  in  1  slave stall.
  m_dat_i  in  WIDTH  read data.
  valid_o  out  1  output stream word available.
  ready_i  in  1  output stream consumer accepts the word.
  data_o  out  WIDTH  output stream data, the FIFO head.

Function
REQ-003 Bus protocol SHALL be pipelined Wishbone only: a request is issued in any cycle with m_cyc_o && m_stb_o && !m_wat_i; acknowledges return in order, one word per m_ack_i.
REQ-004 The FSM SHALL have exactly three states, IDLE, FETCH and DRAIN, with the following transitions:
  IDLE -> FETCH on start_i with count_i != 0.
  IDLE stays in IDLE on start_i with count_i == 0, and done_o pulses on the next cycle.
  FETCH -> DRAIN when the last request issues, or when abort_i is high.
  DRAIN -> IDLE when the outstanding count reaches 0; done_o pulses for one cycle on that transition.
REQ-005 The remaining-request counter (CBITS wide) SHALL load count_i on start and decrement by one on each issued request; it never underflows.
REQ-006 The outstanding counter (FBITS+1 wide) SHALL increment on issue and decrement on m_ack_i. When both occur in the same cycle, the counter is unchanged.
REQ-007 Credit rule: m_stb_o SHALL be asserted only in FETCH, with remaining != 0, and fifo_count + outstanding < 2^FBITS, using registered values only. The FIFO therefore never overflows.
REQ-008 m_stb_o SHALL be held high while m_wat_i is high. The remaining count does not change during a stall.
REQ-009 m_cyc_o SHALL be high in FETCH and DRAIN and low in IDLE.
REQ-010 m_bst_o SHALL equal m_stb_o && (remaining > 1).
REQ-011 Each m_ack_i SHALL write m_dat_i into the FIFO in the same clock edge.
REQ-012 valid_o SHALL equal FIFO not-empty. A word is popped on valid_o && ready_i. Push and pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-013 Output latency SHALL be one cycle: a word acked at edge N is visible on data_o/valid_o after edge N.
REQ-014 m_ack_i with outstanding == 0 is a protocol error; it SHALL be ignored (no push, no counter change).
REQ-015 abort_i SHALL NOT discard data: outstanding acks are still enqueued, and words already in the FIFO remain poppable after done_o.
REQ-016 start_i while busy_o is high SHALL be ignored.

Reset
REQ-017 On rst_i high, asynchronously, the block SHALL be in state IDLE with all counters 0, the FIFO empty, and m_cyc_o, m_stb_o, m_bst_o, busy_o, done_o and valid_o all 0.
REQ-018 Reset mid-transfer SHALL drop m_cyc_o immediately. Acks arriving after reset release SHALL be ignored, as in REQ-014.

Structure
REQ-019 The global `__WB_CLASSIC` option SHALL come from tartcfg.v; this block SHALL raise a compile-time error if it is defined.
REQ-020 FSM state encodings SHALL be localparams in this module. No shared typedefs are needed.
REQ-021 The FIFO SHALL be one sub-module, wb_fetch_fifo, with parameters WIDTH and FBITS and the same asynchronous reset. It provides push, pop, count, empty, full and a registered head output.

Verification
REQ-022 Reset with start_i=1, count_i=5 -> no bus activity; after release, busy_o=0 and valid_o=0.
REQ-023 start_i, count_i=6, slave acks 1 cycle after each request with no stalls, ready_i=1 -> exactly 6 requests issued; words D0..D5 appear in order; m_bst_o low on the 6th request; done_o pulses once after ack 6.
REQ-024 count_i=10, ready_i=0 -> exactly 4 requests issued, then m_stb_o=0 with valid_o=1. Raising ready_i resumes issue; all 10 words are delivered in order.
REQ-025 m_wat_i high for 3 cycles on the 2nd request, count_i=3 -> m_stb_o held for those 3 cycles; exactly 3 requests issued; remaining is unchanged during the stall.
REQ-026 count_i=8, abort_i asserted after 3 requests issued with 2 outstanding -> no further strobes; 2 more acks enqueued; done_o pulses; 3 words readable.
REQ-027 start_i with count_i=0 -> done_o pulses on the next cycle; m_cyc_o stays 0; busy_o stays 0.

Source files
------------

// File: rtl/wb_fetch_pkg.sv
// Shared helpers for the wb_fetch read-stream master and its FIFO.
`timescale 1ns/1ps
package wb_fetch_pkg;

    function automatic int unsigned fifo_depth(input int unsigned fbits);
        return 32'd1 << fbits;
    endfunction

endpackage

// File: rtl/wb_fetch_fifo.sv
// Small power-of-two FIFO with a registered head word, so data_o is a flop output.
`timescale 1ns/1ps
module wb_fetch_fifo
    import wb_fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [FBITS:0]   count_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int DEPTH = int'(fifo_depth(FBITS));
    localparam logic [FBITS:0] L_DEPTH = DEPTH[FBITS:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [FBITS-1:0] r_wr_ptr;
    logic [FBITS-1:0] r_rd_ptr;
    logic [FBITS:0]   r_count;
    logic [WIDTH-1:0] r_head;
    logic [FBITS-1:0] w_rd_next;
    logic             w_push;
    logic             w_pop;

    assign w_pop     = pop_i && (r_count != '0);
    assign w_push    = push_i && ((r_count != L_DEPTH) || w_pop);
    assign w_rd_next = w_pop ? r_rd_ptr + FBITS'(1) : r_rd_ptr;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FBITS'(1);
            end
            r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The word being written becomes the head when it lands in the next read slot.
            if (w_push && (r_wr_ptr == w_rd_next)) begin
                r_head <= din_i;
            end else begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

    assign dout_o  = r_head;
    assign count_o = r_count;
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == L_DEPTH);

endmodule

// File: rtl/wb_fetch.sv
// Pipelined Wishbone read master: fetches count_i words into a credit-limited
// FIFO and presents them as a valid/ready stream.
`timescale 1ns/1ps
module wb_fetch
    import wb_fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CBITS = 10,
    parameter int FBITS = 2,
    parameter int DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CBITS-1:0] count_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    output logic             m_bst_o,
    input  logic             m_ack_i,
    input  logic             m_wat_i,
    input  logic [WIDTH-1:0] m_dat_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);
    localparam int DEPTH = int'(fifo_depth(FBITS));
    localparam logic [FBITS+1:0] L_DEPTH = DEPTH[FBITS+1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        FETCH = S_FETCH,
        DRAIN = S_DRAIN
    } state_t;

`ifdef __WB_CLASSIC
    if (1) begin : g_classic_unsupported
        $error("wb_fetch supports pipelined Wishbone only; __WB_CLASSIC must not be defined");
    end
`endif

    if (DELAY < 0) begin : g_bad_delay
        $error("wb_fetch: DELAY must be non-negative");
    end

    state_t           r_state;
    state_t           w_next;
    logic [CBITS-1:0] r_remaining;
    logic [FBITS:0]   r_outstanding;
    logic [FBITS:0]   w_out_next;
    logic             r_done;
    logic             w_done_next;
    logic [FBITS:0]   w_fifo_count;
    logic [FBITS+1:0] w_credit_sum;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_issue;
    logic             w_ack_ok;
    logic             w_push;
    logic             w_pop;

    // Credit counts both buffered words and requests still in flight.
    assign w_credit_sum = {1'b0, w_fifo_count} + {1'b0, r_outstanding};

    assign m_stb_o  = (r_state == FETCH) && (r_remaining != '0) && (w_credit_sum < L_DEPTH);
    assign m_cyc_o  = (r_state != IDLE);
    assign busy_o   = (r_state != IDLE);
    assign m_we_o   = 1'b0;
    assign m_bst_o  = m_stb_o && (r_remaining > CBITS'(1));
    assign done_o   = r_done;

    assign w_issue  = m_cyc_o && m_stb_o && !m_wat_i;
    assign w_ack_ok = m_ack_i && (r_outstanding != '0);
    assign valid_o  = !w_fifo_empty;
    assign w_pop    = valid_o && ready_i;
    assign w_push   = w_ack_ok && (!w_fifo_full || w_pop);

    always_comb begin
        w_out_next = r_outstanding;
        case ({w_issue, w_ack_ok})
            2'b10:   w_out_next = r_outstanding + 1'b1;
            2'b01:   w_out_next = r_outstanding - 1'b1;
            default: w_out_next = r_outstanding;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_done_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (count_i != '0) begin
                        w_next = FETCH;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort_i || (w_issue && (r_remaining == CBITS'(1)))) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_next == '0) begin
                    w_next      = IDLE;
                    w_done_next = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_done        <= w_done_next;
            r_outstanding <= w_out_next;
            if ((r_state == IDLE) && start_i) begin
                r_remaining <= count_i;
            end else if (w_issue) begin
                r_remaining <= r_remaining - CBITS'(1);
            end
        end
    end

    wb_fetch_fifo #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (m_dat_i),
        .dout_o  (data_o),
        .count_o (w_fifo_count),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

endmodule

// File: tb/tb_wb_fetch.sv
// Directed bench for wb_fetch with a latency-programmable slave and a queue model.
`timescale 1ns/1ps
module tb_wb_fetch;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [9:0] count_i;
    logic       abort_i;
    logic       busy_o, done_o, m_cyc_o, m_stb_o, m_we_o, m_bst_o;
    logic       m_ack_i, m_wat_i;
    logic [7:0] m_dat_i;
    logic       valid_o, ready_i;
    logic [7:0] data_o;

    wb_fetch dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .count_i(count_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_bst_o(m_bst_o),
        .m_ack_i(m_ack_i), .m_wat_i(m_wat_i), .m_dat_i(m_dat_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    int vec = 0;
    int err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // slave configuration, written by the test sequence
    int       lat       = 1;
    logic [7:0] base    = 8'h00;
    int       stall_idx = -1;
    int       stall_len = 0;
    bit       force_wat = 1'b0;
    bit       inject    = 1'b0;

    initial begin : slave
        int pq[$];
        int cyc_n      = 0;
        int slv_iss    = 0;
        int stall_left = 0;
        int seq        = 0;
        m_ack_i = 1'b0;
        m_wat_i = 1'b0;
        m_dat_i = 8'h00;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                pq.delete();
                slv_iss    = 0;
                stall_left = 0;
            end else begin
                if (!busy_o && start_i) begin
                    seq = 0; slv_iss = 0; stall_left = stall_len;
                end
                if (m_cyc_o && m_stb_o && !m_wat_i) begin
                    pq.push_back(cyc_n + lat);
                    slv_iss++;
                end
            end
            @(posedge clk_i);
            cyc_n++;
            #1;
            m_ack_i = 1'b0;
            if (pq.size() > 0 && pq[0] <= cyc_n) begin
                void'(pq.pop_front());
                m_ack_i = 1'b1;
                m_dat_i = base + 8'(seq);
                seq++;
            end else if (inject) begin
                m_ack_i = 1'b1;
                m_dat_i = 8'hEE;
            end
            m_wat_i = force_wat;
            if (stall_left > 0 && slv_iss == stall_idx) begin
                m_wat_i = 1'b1;
                stall_left--;
            end
        end
    end

    // transaction-level model: expected FIFO contents and in-flight requests
    logic [7:0] mq[$];
    logic [7:0] got[$];
    int m_out = 0, m_iss = 0, m_xfer = 0, done_cnt = 0, stall_cyc = 0;
    bit m_abort = 0, prev_stall = 0, prev_abort = 0, last_bst = 0;

    initial begin : mon
        int  rem;
        bit  exp_stb, issue, acc;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                chk("reset_outputs", {m_cyc_o, m_stb_o, m_bst_o, busy_o, done_o, valid_o}, 0);
                mq.delete();
                m_out = 0; m_iss = 0; m_xfer = 0; m_abort = 0;
                prev_stall = 0; prev_abort = 0;
            end else begin
                rem     = m_xfer - m_iss;
                exp_stb = m_cyc_o && !m_abort && (rem > 0) && ((mq.size() + m_out) < 4);
                chk("stb", m_stb_o, exp_stb);
                chk("bst", m_bst_o, exp_stb && (rem > 1));
                chk("we", m_we_o, 0);
                chk("cyc_busy", m_cyc_o, busy_o);
                chk("valid", valid_o, mq.size() != 0);
                if (valid_o && ready_i && mq.size() > 0) begin
                    chk("data", data_o, mq[0]);
                    got.push_back(mq.pop_front());
                end
                if (prev_stall && !prev_abort) chk("stall_hold", m_stb_o, 1);
                if (m_stb_o && m_wat_i) begin
                    stall_cyc++;
                    chk("stall_rem", dut.r_remaining, rem);
                end
                if (done_o) begin
                    done_cnt++;
                    chk("done_idle", {busy_o, m_out != 0}, 0);
                end
                issue = m_cyc_o && m_stb_o && !m_wat_i;
                acc   = m_ack_i && (m_out > 0);
                if (acc) begin
                    mq.push_back(m_dat_i);
                    m_out--;
                end
                if (issue) begin
                    m_iss++;
                    m_out++;
                    last_bst = m_bst_o;
                end
                if (busy_o && abort_i) m_abort = 1;
                if (!busy_o && start_i) begin
                    m_xfer = int'(count_i); m_iss = 0; m_abort = 0;
                    got.delete(); done_cnt = 0; stall_cyc = 0;
                end
                prev_stall = m_stb_o && m_wat_i;
                prev_abort = abort_i;
            end
        end
    end

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    task automatic go(input int n);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        count_i = 10'(n);
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while ((busy_o || (ready_i && mq.size() != 0)) && k < maxc) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= maxc) chk("timeout", 0, 1);
        repeat (2) @(negedge clk_i);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : seq_main
        int k;
        rst_i = 1'b1; start_i = 1'b1; count_i = 10'd5; abort_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("r022_no_bus", {m_cyc_o, m_stb_o}, 0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        rst_i   = 1'b0;
        @(negedge clk_i); #1;
        chk("r022_busy", busy_o, 0);
        chk("r022_valid", valid_o, 0);

        // six words, back-to-back acks; a start pulse mid-transfer must be ignored
        base = 8'h10; lat = 1;
        go(6);
        @(posedge clk_i); #1; start_i = 1'b1; count_i = 10'd2;
        @(posedge clk_i); #1; start_i = 1'b0;
        wait_idle(100);
        chk("r023_reqs", m_iss, 6);
        chk("r023_words", got.size(), 6);
        chk("r023_d0", got_at(0), 8'h10);
        chk("r023_d5", got_at(5), 8'h15);
        chk("r023_last_bst", last_bst, 0);
        chk("r023_done", done_cnt, 1);

        // consumer stalled: credit limits issue to four requests
        base = 8'h40; ready_i = 1'b0;
        go(10);
        repeat (12) @(negedge clk_i);
        #1;
        chk("r024_reqs_held", m_iss, 4);
        chk("r024_stb", m_stb_o, 0);
        chk("r024_valid", valid_o, 1);
        @(posedge clk_i); #1; ready_i = 1'b1;
        wait_idle(200);
        chk("r024_words", got.size(), 10);
        chk("r024_d0", got_at(0), 8'h40);
        chk("r024_d9", got_at(9), 8'h49);
        chk("r024_done", done_cnt, 1);

        // three-cycle slave stall on the second request
        base = 8'h70; stall_idx = 1; stall_len = 3;
        go(3);
        wait_idle(100);
        stall_len = 0; stall_idx = -1;
        chk("r025_reqs", m_iss, 3);
        chk("r025_stall_cycles", stall_cyc, 3);
        chk("r025_words", got.size(), 3);
        chk("r025_d2", got_at(2), 8'h72);

        // abort with two requests in flight; data still lands in the FIFO
        base = 8'hA0; lat = 2; ready_i = 1'b0;
        go(8);
        k = 0;
        while (m_iss < 3 && k < 50) begin
            @(negedge clk_i); #1; k++;
        end
        if (k >= 50) chk("r026_timeout", 0, 1);
        force_wat = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b1;
        chk("r026_outstanding", dut.r_outstanding, 2);
        @(negedge clk_i); force_wat = 1'b0;
        @(posedge clk_i); #1; abort_i = 1'b0;
        wait_idle(100);
        chk("r026_reqs", m_iss, 3);
        chk("r026_done", done_cnt, 1);
        chk("r026_valid_after_done", valid_o, 1);
        @(posedge clk_i); #1; ready_i = 1'b1;
        wait_idle(100);
        chk("r026_words", got.size(), 3);
        chk("r026_d2", got_at(2), 8'hA2);
        lat = 1;

        // zero-length fetch
        @(posedge clk_i); #1; start_i = 1'b1; count_i = 10'd0;
        @(posedge clk_i); #1; start_i = 1'b0;
        @(negedge clk_i); #1;
        chk("r027_done", done_o, 1);
        chk("r027_cyc", m_cyc_o, 0);
        chk("r027_busy", busy_o, 0);
        @(negedge clk_i); #1;
        chk("r027_done_pulse", done_o, 0);

        // stray ack while idle
        @(negedge clk_i); inject = 1'b1;
        @(negedge clk_i); inject = 1'b0;
        @(negedge clk_i); #1;
        chk("r014_valid", valid_o, 0);
        chk("r014_outstanding", dut.r_outstanding, 0);

        // reset in the middle of a transfer, then a late ack
        base = 8'hC0;
        go(8);
        k = 0;
        while (m_iss < 3 && k < 50) begin
            @(negedge clk_i); #1; k++;
        end
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        chk("r018_cyc_drop", m_cyc_o, 0);
        chk("r018_busy_drop", busy_o, 0);
        @(negedge clk_i);
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i); inject = 1'b1;
        @(negedge clk_i); inject = 1'b0;
        @(negedge clk_i); #1;
        chk("r018_valid", valid_o, 0);
        chk("r018_outstanding", dut.r_outstanding, 0);
        chk("r018_busy", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
